// File: rtl/reorder_buffer_pkg.sv
// Shared sizes, tag encoding and per-entry record for the reorder buffer.
package reorder_buffer_pkg;

  localparam int ROB_SIZE = 32;
  localparam int IDX_W    = $clog2(ROB_SIZE);
  localparam int ENTRY_W  = IDX_W + 1;
  localparam int CNT_W    = IDX_W + 1;

  // One past the last real tag means "no tag".
  localparam logic [ENTRY_W-1:0] ENTRY_NULL = ENTRY_W'(ROB_SIZE);

  typedef struct packed {
    logic        is_store;
    logic        is_branch;
    logic [4:0]  rd;
    logic [31:0] pred_pc;
    logic [31:0] real_pc;
  } rob_entry_t;

  function automatic logic is_tag(input logic [ENTRY_W-1:0] entry);
    return entry < ENTRY_NULL;
  endfunction

endpackage

// File: rtl/reorder_buffer_tag_lookup.sv
// Combinational operand-tag lookup for the issue stage, with same-cycle CDB bypass.
module rob_tag_lookup
  import reorder_buffer_pkg::*;
(
  input  logic [ENTRY_W-1:0]  query_entry,
  input  logic [ROB_SIZE-1:0] entry_valid,
  input  logic [ROB_SIZE-1:0] entry_ready,
  input  logic [31:0]         entry_value [ROB_SIZE],
  input  logic                alu_broadcast,
  input  logic [ENTRY_W-1:0]  alu_entry,
  input  logic [31:0]         alu_value,
  input  logic                lsb_broadcast,
  input  logic [ENTRY_W-1:0]  lsb_entry,
  input  logic [31:0]         lsb_value,
  output logic                query_ready,
  output logic [31:0]         query_value
);

  logic [IDX_W-1:0] idx;
  assign idx = query_entry[IDX_W-1:0];

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    query_ready = 1'b0;
    query_value = '0;
    if (is_tag(query_entry)) begin
      if (alu_broadcast && alu_entry == query_entry) begin
        query_ready = 1'b1;
        query_value = alu_value;
      end else if (lsb_broadcast && lsb_entry == query_entry) begin
        query_ready = 1'b1;
        query_value = lsb_value;
      end else if (entry_valid[idx] && entry_ready[idx]) begin
        query_ready = 1'b1;
        query_value = entry_value[idx];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: tag allocation, CDB capture, operand lookup and in-order retirement with mispredict flush.
// Defining ROB_BRANCH_STAT_EN adds the stat_branches / stat_mispredicts counters and ports.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rd,
  input  logic               issue_is_store,
  input  logic               issue_is_branch,
  input  logic [31:0]        issue_pred_pc,
  output logic [ENTRY_W-1:0] issue_entry,
  output logic               rob_full,
  input  logic [ENTRY_W-1:0] query_j_entry,
  output logic               query_j_ready,
  output logic [31:0]        query_j_value,
  input  logic [ENTRY_W-1:0] query_k_entry,
  output logic               query_k_ready,
  output logic [31:0]        query_k_value,
  input  logic               alu_broadcast,
  input  logic [ENTRY_W-1:0] alu_entry,
  input  logic [31:0]        alu_value,
  input  logic [31:0]        alu_pc_out,
  input  logic               lsb_broadcast,
  input  logic [ENTRY_W-1:0] lsb_entry,
  input  logic [31:0]        lsb_value,
  output logic               rob_commit,
  output logic [ENTRY_W-1:0] rob_entry,
  output logic [31:0]        rob_result,
  output logic [4:0]         rob_rd,
  output logic               rob_store_commit,
  output logic               roll_back,
  output logic [31:0]        roll_back_pc
`ifdef ROB_BRANCH_STAT_EN
  ,
  output logic [31:0]        stat_branches,
  output logic [31:0]        stat_mispredicts
`endif
);

  logic [IDX_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q;
  logic [ROB_SIZE-1:0] valid_q, ready_q;
  rob_entry_t          entry_q [ROB_SIZE];
  logic [31:0]         value_q [ROB_SIZE];

  rob_entry_t       head_rec;
  logic [IDX_W-1:0] alu_idx, lsb_idx;
  logic             head_fire, mispredict, do_issue, alu_hit, lsb_hit;

  assign issue_entry = {1'b0, tail_q};
  assign rob_full    = (count_q == CNT_W'(ROB_SIZE));

  assign head_rec = entry_q[head_q];
  assign alu_idx  = alu_entry[IDX_W-1:0];
  assign lsb_idx  = lsb_entry[IDX_W-1:0];

  // Everything below is gated by rdy_in so a paused core sees no state change.
  assign head_fire  = rdy_in && valid_q[head_q] && ready_q[head_q];
  assign mispredict = head_fire && head_rec.is_branch && (head_rec.real_pc != head_rec.pred_pc);
  assign do_issue   = rdy_in && issue_valid && !rob_full;
  assign alu_hit    = rdy_in && alu_broadcast && is_tag(alu_entry) && valid_q[alu_idx];
  assign lsb_hit    = rdy_in && lsb_broadcast && is_tag(lsb_entry) && valid_q[lsb_idx];

  // Pointers, occupancy and per-entry status.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      ready_q <= '0;
    end else if (mispredict) begin
      // Flush discards younger entries, same-cycle captures and any issue.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      ready_q <= '0;
    end else begin
      if (alu_hit) ready_q[alu_idx] <= 1'b1;
      if (lsb_hit) ready_q[lsb_idx] <= 1'b1;
      if (head_fire) begin
        valid_q[head_q] <= 1'b0;
        ready_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (do_issue) begin
        valid_q[tail_q] <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(do_issue) - CNT_W'(head_fire);
    end
  end

  // NOTE: payload storage has no reset; the valid bits alone decide whether an entry's contents mean anything.
  always_ff @(posedge clk_in) begin
    if (do_issue) begin
      entry_q[tail_q] <= '{is_store:  issue_is_store,
                           is_branch: issue_is_branch,
                           rd:        issue_rd,
                           pred_pc:   issue_pred_pc,
                           real_pc:   issue_pred_pc};
    end
    if (alu_hit) begin
      value_q[alu_idx]         <= alu_value;
      entry_q[alu_idx].real_pc <= alu_pc_out;
    end
    if (lsb_hit) value_q[lsb_idx] <= lsb_value;
  end

  // Registered retire strobes; payload holds between commits.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rob_commit       <= 1'b0;
      rob_entry        <= ENTRY_NULL;
      rob_result       <= '0;
      rob_rd           <= '0;
      rob_store_commit <= 1'b0;
      roll_back        <= 1'b0;
      roll_back_pc     <= '0;
    end else begin
      rob_commit       <= head_fire;
      rob_store_commit <= head_fire && head_rec.is_store;
      roll_back        <= mispredict;
      if (head_fire) begin
        rob_entry  <= {1'b0, head_q};
        rob_result <= value_q[head_q];
        rob_rd     <= head_rec.rd;
      end
      if (mispredict) roll_back_pc <= head_rec.real_pc;
    end
  end

`ifdef ROB_BRANCH_STAT_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (head_fire && head_rec.is_branch) stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

  rob_tag_lookup u_lookup_j (
    .query_entry   (query_j_entry),
    .entry_valid   (valid_q),
    .entry_ready   (ready_q),
    .entry_value   (value_q),
    .alu_broadcast (alu_broadcast),
    .alu_entry     (alu_entry),
    .alu_value     (alu_value),
    .lsb_broadcast (lsb_broadcast),
    .lsb_entry     (lsb_entry),
    .lsb_value     (lsb_value),
    .query_ready   (query_j_ready),
    .query_value   (query_j_value)
  );

  rob_tag_lookup u_lookup_k (
    .query_entry   (query_k_entry),
    .entry_valid   (valid_q),
    .entry_ready   (ready_q),
    .entry_value   (value_q),
    .alu_broadcast (alu_broadcast),
    .alu_entry     (alu_entry),
    .alu_value     (alu_value),
    .lsb_broadcast (lsb_broadcast),
    .lsb_entry     (lsb_entry),
    .lsb_value     (lsb_value),
    .query_ready   (query_k_ready),
    .query_value   (query_k_value)
  );

endmodule
